// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative SLL/SRL/SRA unit with valid/ready on both sides
// SHIFT_SEQ_DOUBLE_STEP_EN: apply two shift steps per SHIFT cycle while count >= 2.
module shift_sequencer #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_op,
   input  logic [SHAMT_W-1:0] in_shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0]         OP_PASS = 2'b00;
   localparam logic [1:0]         OP_SLL  = 2'b01;
   localparam logic [1:0]         OP_SRL  = 2'b10;
   localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
   localparam logic [SHAMT_W-1:0] CNT_TWO = SHAMT_W'(2);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [1:0]         op_q, op_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
         default: r = {d[WIDTH-1], d[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         op_q    <= OP_PASS;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_op == OP_PASS || in_shamt == '0) state_d = S_DONE;
               else                                    state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
            if (cnt_q <= CNT_TWO) state_d = S_DONE;
`else
            if (cnt_q == CNT_ONE) state_d = S_DONE;
`endif
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operands are sampled only on the accept edge; the registers own the operation after that.
   always_comb begin
      data_d = data_q;
      op_d   = op_q;
      cnt_d  = cnt_q;
      if (state_q == S_IDLE && in_valid) begin
         data_d = in_data;
         op_d   = in_op;
         cnt_d  = in_shamt;
      end else if (state_q == S_SHIFT) begin
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
         if (cnt_q >= CNT_TWO) begin
            data_d = shift_step(shift_step(data_q, op_q), op_q);
            cnt_d  = cnt_q - CNT_TWO;
         end else begin
            data_d = shift_step(data_q, op_q);
            cnt_d  = cnt_q - CNT_ONE;
         end
`else
         data_d = shift_step(data_q, op_q);
         cnt_d  = cnt_q - CNT_ONE;
`endif
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_DONE);
      out_data  = data_q;
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed-vector bench for shift_sequencer
module tb_shift_sequencer;

   localparam int WIDTH   = 16;
   localparam int SHAMT_W = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_op;
   logic [SHAMT_W-1:0] in_shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               busy;

   int n_cmp = 0;
   int n_bad = 0;

   shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_op    (in_op),
      .in_shamt (in_shamt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int n);
      if (n == 0) return 1;
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
      return (n + 1) / 2 + 1;
`else
      return n + 1;
`endif
   endfunction

   task automatic issue(input logic [15:0] d, input logic [1:0] op, input logic [3:0] sh,
                        input bit scramble);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_op    = op;
      in_shamt = sh;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (scramble) begin
         in_data  = ~d;
         in_op    = ~op;
         in_shamt = ~sh;
      end
   endtask

   task automatic await_result(input string tag, input logic [15:0] exp_data, input int exp_l);
      int lat = 0;
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_in_ready_low"}, in_ready, 0);
         end
         if (out_valid) got = 1'b1;
      end
      check({tag, "_valid_seen"}, got, 1);
      check({tag, "_latency"}, lat, exp_l);
      check({tag, "_data"}, out_data, exp_data);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_in_ready_back"}, in_ready, 1);
      check({tag, "_out_valid_drop"}, out_valid, 0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] sh, input logic [15:0] exp_data);
      issue(d, op, sh, 1'b0);
      await_result(tag, exp_data, exp_lat((op == 2'b00) ? 0 : int'(sh)));
      release_result(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_op     = '0;
      in_shamt  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      run_op("sll_1_by_4",     16'h0001, 2'b01, 4'd4,  16'h0010);
      run_op("sra_8000_by_15", 16'h8000, 2'b11, 4'd15, 16'hFFFF);
      run_op("srl_8000_by_15", 16'h8000, 2'b10, 4'd15, 16'h0001);
      run_op("pass_a5a5",      16'hA5A5, 2'b00, 4'd9,  16'hA5A5);
      run_op("sll_by_0",       16'h1234, 2'b01, 4'd0,  16'h1234);
      run_op("sra_pos_by_3",   16'h4000, 2'b11, 4'd3,  16'h0800);
      run_op("sll_8001_by_1",  16'h8001, 2'b01, 4'd1,  16'h0002);

      // Backpressure: hold the result, poke a request that must be ignored
      issue(16'h00F0, 2'b10, 4'd2, 1'b0);
      await_result("bp", 16'h003C, exp_lat(2));
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            in_valid = 1'b1;
            in_data  = 16'h7777;
            in_op    = 2'b01;
            in_shamt = 4'd1;
         end
         if (k == 2) in_valid = 1'b0;
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_data", out_data, 16'h003C);
         check("bp_hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      release_result("bp");
      @(negedge clk);
      check("bp_no_late_accept", busy, 0);

      // Reset on the third SHIFT cycle of a long SLL
      issue(16'h00FF, 2'b01, 4'd12, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst_srl", 16'hF0F0, 2'b10, 4'd4, 16'h0F0F);

      // Inputs scrambled right after the accept edge
      issue(16'h0003, 2'b01, 4'd2, 1'b1);
      await_result("scramble", 16'h000C, exp_lat(2));
      release_result("scramble");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
